writeback_regfile: RTL and testbench

- Downstream consumer of the execute stage; also the source of its register operands.
- Accepts ALU write-backs and load-return data, and commits at most one register write per cycle to an 8x8 register file, strictly in program order.
- A small hold FIFO absorbs write-port conflicts.
- Provides two registered read ports with full write-through/forwarding, so execute sees operand data 1 cycle after decode drives the selects.

---
 rtl/writeback_regfile_if.sv | 36 +++
 rtl/writeback_regfile.sv | 145 ++++++++++++++
 tb/tb_writeback_regfile.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/writeback_regfile_if.sv
// Write-back bus between execute/decode and the register file: write sources,
// read selects, read data and the commit trace.
interface writeback_regfile_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
);
  logic              alu_wr_en;
  logic [SEL_W-1:0]  alu_wr_sel;
  logic [DATA_W-1:0] alu_wr_data;
  logic              ld_req;
  logic [SEL_W-1:0]  ld_dst;
  logic [DATA_W-1:0] d_mem_data_in;
  logic [SEL_W-1:0]  rd_sel0;
  logic [SEL_W-1:0]  rd_sel1;
  logic [DATA_W-1:0] rd_data0;
  logic [DATA_W-1:0] rd_data1;
  logic              wb_stall;
  logic              wb_commit_en;
  logic [SEL_W-1:0]  wb_commit_sel;
  logic [DATA_W-1:0] wb_commit_data;
  logic              wb_overflow;

  modport master (
    output alu_wr_en, alu_wr_sel, alu_wr_data, ld_req, ld_dst, d_mem_data_in,
           rd_sel0, rd_sel1,
    input  rd_data0, rd_data1, wb_stall, wb_commit_en, wb_commit_sel,
           wb_commit_data, wb_overflow
  );

  modport slave (
    input  alu_wr_en, alu_wr_sel, alu_wr_data, ld_req, ld_dst, d_mem_data_in,
           rd_sel0, rd_sel1,
    output rd_data0, rd_data1, wb_stall, wb_commit_en, wb_commit_sel,
           wb_commit_data, wb_overflow
  );
endinterface

// File: rtl/writeback_regfile.sv
// In-order write-back register file: one commit per cycle, a small hold FIFO
// for port conflicts, and two registered read ports with full forwarding.
module writeback_regfile #(
  parameter int DATA_W     = 8,
  parameter int NUM_REGS   = 8,
  parameter int HOLD_DEPTH = 2
) (
  input logic               clk,
  input logic               reset_,
  writeback_regfile_if.slave wb
);
  localparam int SEL_W = $clog2(NUM_REGS);
  localparam int PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
  localparam int CNT_W = $clog2(HOLD_DEPTH + 1);

  logic [DATA_W-1:0] regs      [NUM_REGS];
  logic [SEL_W-1:0]  hold_sel  [HOLD_DEPTH];
  logic [DATA_W-1:0] hold_data [HOLD_DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  hold_count;
  logic              ld_pend;
  logic [SEL_W-1:0]  ld_dst_q;

  logic              in0_v, in1_v, in0_acc, in1_acc;
  logic [SEL_W-1:0]  in0_sel, in1_sel;
  logic [DATA_W-1:0] in0_data, in1_data;
  logic              pop, commit_v, push0_v, push1_v, acc0, acc1, drop;
  logic [SEL_W-1:0]  commit_sel, push0_sel;
  logic [DATA_W-1:0] commit_data, push0_data;
  int                space, n_acc;

  logic [SEL_W-1:0]  rd_sel_a [2];
  logic [DATA_W-1:0] rd_fwd   [2];

  logic [DATA_W-1:0] rd_data0_q, rd_data1_q, commit_data_q;
  logic [SEL_W-1:0]  commit_sel_q;
  logic              commit_en_q, overflow_q;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= HOLD_DEPTH) s = s - HOLD_DEPTH;
    return PTR_W'(s);
  endfunction

  // in0 is always the older incoming write: a load return beats a same-cycle ALU write
  always_comb begin
    in1_v    = 1'b0;
    in1_sel  = wb.alu_wr_sel;
    in1_data = wb.alu_wr_data;
    if (ld_pend) begin
      in0_v    = 1'b1;
      in0_sel  = ld_dst_q;
      in0_data = wb.d_mem_data_in;
      in1_v    = wb.alu_wr_en;
    end else begin
      in0_v    = wb.alu_wr_en;
      in0_sel  = wb.alu_wr_sel;
      in0_data = wb.alu_wr_data;
    end
  end

  always_comb begin
    pop         = (hold_count != '0);
    commit_v    = pop ? 1'b1 : in0_v;
    commit_sel  = pop ? hold_sel[head] : in0_sel;
    commit_data = pop ? hold_data[head] : in0_data;
    push0_v     = pop ? in0_v : in1_v;
    push0_sel   = pop ? in0_sel : in1_sel;
    push0_data  = pop ? in0_data : in1_data;
    push1_v     = pop & in1_v;
    // the pop frees its slot before any push lands
    space       = HOLD_DEPTH - int'(hold_count) + (pop ? 1 : 0);
    acc0        = push0_v && (space >= 1);
    acc1        = push1_v && (space >= 2);
    drop        = (push0_v && !acc0) || (push1_v && !acc1);
    n_acc       = int'(acc0) + int'(acc1);
    in0_acc     = pop ? acc0 : in0_v;
    in1_acc     = pop ? acc1 : acc0;
  end

  assign rd_sel_a[0] = wb.rd_sel0;
  assign rd_sel_a[1] = wb.rd_sel1;

  // Forwarding applied oldest-to-youngest so the last match wins; dropped writes are invisible
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_fwd[p] = regs[rd_sel_a[p]];
      if (commit_v && commit_sel == rd_sel_a[p]) rd_fwd[p] = commit_data;
      for (int i = 0; i < HOLD_DEPTH; i++) begin
        if (i < int'(hold_count) && hold_sel[ptr_add(head, i)] == rd_sel_a[p])
          rd_fwd[p] = hold_data[ptr_add(head, i)];
      end
      if (in0_acc && in0_sel == rd_sel_a[p]) rd_fwd[p] = in0_data;
      if (in1_acc && in1_sel == rd_sel_a[p]) rd_fwd[p] = in1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      head          <= '0;
      tail          <= '0;
      hold_count    <= '0;
      ld_pend       <= 1'b0;
      ld_dst_q      <= '0;
      rd_data0_q    <= '0;
      rd_data1_q    <= '0;
      commit_en_q   <= 1'b0;
      commit_sel_q  <= '0;
      commit_data_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      ld_pend  <= wb.ld_req;
      ld_dst_q <= wb.ld_dst;
      if (commit_v) regs[commit_sel] <= commit_data;
      if (acc0) begin
        hold_sel[tail]  <= push0_sel;
        hold_data[tail] <= push0_data;
      end
      if (acc1) begin
        hold_sel[ptr_add(tail, 1)]  <= in1_sel;
        hold_data[ptr_add(tail, 1)] <= in1_data;
      end
      head          <= pop ? ptr_add(head, 1) : head;
      tail          <= ptr_add(tail, n_acc);
      hold_count    <= CNT_W'(int'(hold_count) - (pop ? 1 : 0) + n_acc);
      rd_data0_q    <= rd_fwd[0];
      rd_data1_q    <= rd_fwd[1];
      commit_en_q   <= commit_v;
      commit_sel_q  <= commit_v ? commit_sel : '0;
      commit_data_q <= commit_v ? commit_data : '0;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign wb.wb_stall = (int'(hold_count) >= HOLD_DEPTH - 1) ||
                       (ld_pend && int'(hold_count) >= HOLD_DEPTH - 2);
  assign wb.rd_data0       = rd_data0_q;
  assign wb.rd_data1       = rd_data1_q;
  assign wb.wb_commit_en   = commit_en_q;
  assign wb.wb_commit_sel  = commit_sel_q;
  assign wb.wb_commit_data = commit_data_q;
  assign wb.wb_overflow    = overflow_q;
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: commit ordering, forwarding, stall,
// overflow and reset behaviour against hand-computed values.
module tb_writeback_regfile;
  logic clk = 1'b0;
  logic reset_;
  int   checks = 0;
  int   failures = 0;

  writeback_regfile_if #(.DATA_W(8), .SEL_W(3)) bus ();

  writeback_regfile #(.DATA_W(8), .NUM_REGS(8), .HOLD_DEPTH(2)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .wb     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic a_en, input logic [2:0] a_sel, input logic [7:0] a_data,
                                input logic l_req, input logic [2:0] l_dst, input logic [7:0] mem);
    bus.alu_wr_en     = a_en;
    bus.alu_wr_sel    = a_sel;
    bus.alu_wr_data   = a_data;
    bus.ld_req        = l_req;
    bus.ld_dst        = l_dst;
    bus.d_mem_data_in = mem;
  endtask

  task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_commit(input string tag, input logic en, input logic [2:0] sel, input logic [7:0] data);
    check_output({tag, ".en"}, 8'(bus.wb_commit_en), 8'(en));
    check_output({tag, ".sel"}, 8'(bus.wb_commit_sel), 8'(sel));
    check_output({tag, ".data"}, bus.wb_commit_data, data);
  endtask

  initial begin
    reset_ = 1'b1;
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    bus.rd_sel0 = 3'd0;
    bus.rd_sel1 = 3'd0;
    tick();
    tick();
    reset_ = 1'b0;
    check_output("reset.rd0", bus.rd_data0, 8'h00);
    check_output("reset.rd1", bus.rd_data1, 8'h00);
    check_commit("reset.commit", 1'b0, 3'd0, 8'h00);
    check_output("reset.overflow", 8'(bus.wb_overflow), 8'h00);
    check_output("reset.stall", 8'(bus.wb_stall), 8'h00);
    for (int i = 0; i < 8; i++) begin
      bus.rd_sel0 = 3'(i);
      bus.rd_sel1 = 3'(7 - i);
      tick();
      check_output($sformatf("reset_read.p0.r%0d", i), bus.rd_data0, 8'h00);
      check_output($sformatf("reset_read.p1.r%0d", 7 - i), bus.rd_data1, 8'h00);
    end

    // ALU write with same-cycle read of the destination
    apply_stimulus(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00);
    bus.rd_sel0 = 3'd3;
    tick();
    check_commit("alu_r3", 1'b1, 3'd3, 8'h5A);
    check_output("alu_r3.fwd", bus.rd_data0, 8'h5A);
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    tick();
    check_commit("alu_r3.idle", 1'b0, 3'd0, 8'h00);
    check_output("alu_r3.array", bus.rd_data0, 8'h5A);

    // Load return collides with ALU write: load commits first
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h00);
    tick();
    check_output("ld_r2.issue.commit_en", 8'(bus.wb_commit_en), 8'h00);
    check_output("ld_r2.issue.stall", 8'(bus.wb_stall), 8'h01);
    apply_stimulus(1'b1, 3'd4, 8'h22, 1'b0, 3'd0, 8'h11);
    bus.rd_sel0 = 3'd2;
    bus.rd_sel1 = 3'd4;
    tick();
    check_commit("ld_r2.ret", 1'b1, 3'd2, 8'h11);
    check_output("ld_r2.rd0", bus.rd_data0, 8'h11);
    check_output("ld_r2.rd1_held_fwd", bus.rd_data1, 8'h22);
    check_output("ld_r2.stall_held", 8'(bus.wb_stall), 8'h01);
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    tick();
    check_commit("alu_r4.drain", 1'b1, 3'd4, 8'h22);
    check_output("alu_r4.stall", 8'(bus.wb_stall), 8'h00);
    check_output("alu_r4.rd0", bus.rd_data0, 8'h11);
    check_output("alu_r4.rd1", bus.rd_data1, 8'h22);

    // WAW: ALU R1 held behind a load, then a younger load to R1
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h00);
    bus.rd_sel0 = 3'd1;
    tick();
    apply_stimulus(1'b1, 3'd1, 8'h01, 1'b1, 3'd1, 8'h33);
    tick();
    check_commit("waw.r5", 1'b1, 3'd5, 8'h33);
    check_output("waw.rd_r1_alu", bus.rd_data0, 8'h01);
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h77);
    tick();
    check_commit("waw.r1_old", 1'b1, 3'd1, 8'h01);
    check_output("waw.rd_r1_load", bus.rd_data0, 8'h77);
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    tick();
    check_commit("waw.r1_new", 1'b1, 3'd1, 8'h77);
    check_output("waw.stall", 8'(bus.wb_stall), 8'h00);
    tick();
    check_output("waw.final_r1", bus.rd_data0, 8'h77);
    check_output("waw.idle", 8'(bus.wb_commit_en), 8'h00);

    // Fill the hold FIFO, then violate the stall
    bus.rd_sel0 = 3'd5;
    bus.rd_sel1 = 3'd6;
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h00);
    tick();
    check_output("fill1.stall", 8'(bus.wb_stall), 8'h01);
    check_output("fill1.overflow", 8'(bus.wb_overflow), 8'h00);
    apply_stimulus(1'b1, 3'd7, 8'hB1, 1'b1, 3'd6, 8'hA1);
    tick();
    check_commit("fill2", 1'b1, 3'd6, 8'hA1);
    check_output("fill2.rd_r6", bus.rd_data1, 8'hA1);
    check_output("fill2.rd_r5", bus.rd_data0, 8'h33);
    apply_stimulus(1'b1, 3'd0, 8'hB2, 1'b1, 3'd6, 8'hA2);
    tick();
    check_commit("fill3", 1'b1, 3'd7, 8'hB1);
    check_output("fill3.rd_r6", bus.rd_data1, 8'hA2);
    check_output("fill3.stall", 8'(bus.wb_stall), 8'h01);
    check_output("fill3.overflow", 8'(bus.wb_overflow), 8'h00);
    apply_stimulus(1'b1, 3'd5, 8'hEE, 1'b0, 3'd0, 8'hA3);
    tick();
    check_commit("ovf", 1'b1, 3'd6, 8'hA2);
    check_output("ovf.flag", 8'(bus.wb_overflow), 8'h01);
    check_output("ovf.rd_r5_not_dropped", bus.rd_data0, 8'h33);
    check_output("ovf.rd_r6", bus.rd_data1, 8'hA3);
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    tick();
    check_commit("drain1", 1'b1, 3'd0, 8'hB2);
    check_output("drain1.rd_r6", bus.rd_data1, 8'hA3);
    tick();
    check_commit("drain2", 1'b1, 3'd6, 8'hA3);
    check_output("drain2.stall", 8'(bus.wb_stall), 8'h00);
    tick();
    check_commit("drain3", 1'b0, 3'd0, 8'h00);
    check_output("drain3.sticky", 8'(bus.wb_overflow), 8'h01);
    check_output("drain3.rd_r5", bus.rd_data0, 8'h33);

    // Reset right after a load issue discards the load
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h00);
    tick();
    reset_ = 1'b1;
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'hFF);
    tick();
    reset_ = 1'b0;
    check_output("rst_ld.overflow", 8'(bus.wb_overflow), 8'h00);
    check_commit("rst_ld.commit", 1'b0, 3'd0, 8'h00);
    check_output("rst_ld.stall", 8'(bus.wb_stall), 8'h00);
    check_output("rst_ld.rd0", bus.rd_data0, 8'h00);
    tick();
    check_output("rst_ld.after.commit_en", 8'(bus.wb_commit_en), 8'h00);
    check_output("rst_ld.after.rd_r5", bus.rd_data0, 8'h00);
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    tick();
    check_output("rst_ld.r5_stays0", bus.rd_data0, 8'h00);
    check_output("rst_ld.stall2", 8'(bus.wb_stall), 8'h00);

    // Both ports on a register that is committing and being pushed at once
    bus.rd_sel0 = 3'd2;
    bus.rd_sel1 = 3'd2;
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h00);
    tick();
    apply_stimulus(1'b1, 3'd2, 8'h20, 1'b1, 3'd2, 8'h10);
    tick();
    check_commit("same1", 1'b1, 3'd2, 8'h10);
    check_output("same1.rd0", bus.rd_data0, 8'h20);
    check_output("same1.rd1", bus.rd_data1, 8'h20);
    apply_stimulus(1'b1, 3'd2, 8'h40, 1'b0, 3'd0, 8'h30);
    tick();
    check_commit("same2", 1'b1, 3'd2, 8'h20);
    check_output("same2.rd0", bus.rd_data0, 8'h40);
    check_output("same2.rd1", bus.rd_data1, 8'h40);
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    tick();
    check_commit("same3", 1'b1, 3'd2, 8'h30);
    check_output("same3.rd0_hold_over_commit", bus.rd_data0, 8'h40);
    check_output("same3.rd1_hold_over_commit", bus.rd_data1, 8'h40);
    tick();
    check_commit("same4", 1'b1, 3'd2, 8'h40);
    tick();
    check_commit("same5", 1'b0, 3'd0, 8'h00);
    check_output("same5.rd0", bus.rd_data0, 8'h40);
    check_output("same5.stall", 8'(bus.wb_stall), 8'h00);
    check_output("same5.overflow", 8'(bus.wb_overflow), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
